// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_R      = 3'd0,
      CLS_I      = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_JAL    = 3'd5,
      CLS_BAD    = 3'd6
   } op_class_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLT = 3'd5;
   localparam logic [2:0] ALU_SLL = 3'd6;
   localparam logic [2:0] ALU_SRL = 3'd7;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   // Map a 7-bit opcode onto the instruction class the FSM sequences by.
   function automatic op_class_t op_class(input logic [6:0] opcode);
      case (opcode)
         OP_R:      op_class = CLS_R;
         OP_I:      op_class = CLS_I;
         OP_LOAD:   op_class = CLS_LOAD;
         OP_STORE:  op_class = CLS_STORE;
         OP_BRANCH: op_class = CLS_BRANCH;
         OP_JAL:    op_class = CLS_JAL;
         default:   op_class = CLS_BAD;
      endcase
   endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decode from instruction class, funct3 and instr[30].
module alu_dec
   import ctrl_pkg::*;
#(
   parameter int unsigned ALUCTR_W = 3
) (
   input  logic [2:0]          funct3,
   input  logic                instr30,
   input  op_class_t           op_cls,
   output logic [ALUCTR_W-1:0] aluctr,
   output logic                illegal
);

   logic [2:0] w_op;

   always_comb begin
      w_op    = ALU_ADD;
      illegal = 1'b0;
      case (op_cls)
         CLS_R, CLS_I: begin
            case (funct3)
               3'b000:  w_op = (op_cls == CLS_R && instr30) ? ALU_SUB : ALU_ADD;
               3'b111:  w_op = ALU_AND;
               3'b110:  w_op = ALU_OR;
               3'b100:  w_op = ALU_XOR;
               3'b010:  w_op = ALU_SLT;
               3'b001:  w_op = ALU_SLL;
               3'b101:  w_op = ALU_SRL;
               default: illegal = 1'b1;
            endcase
         end
         CLS_BRANCH: w_op = ALU_SUB;
         default:    w_op = ALU_ADD;
      endcase
   end

   assign aluctr = ALUCTR_W'(w_op);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing with bounded
// memory handshake, sticky trap and retired-instruction counter.
module mc_control_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned TIMEOUT  = 15,
   parameter int unsigned ALUCTR_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         instr,
   input  logic                mem_ready,
   input  logic                branch_taken,
   output logic                mem_req,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_src,
   output logic [ALUCTR_W-1:0] aluctr,
   output logic                immadd,
   output logic                branch,
   output logic                memread,
   output logic                memwrite,
   output logic                memtoreg,
   output logic                regwrite,
   output logic                wb_link,
   output logic [2:0]          funct,
   output logic                trap,
   output logic [1:0]          cause,
   output logic [CNT_W-1:0]    instret
);

   localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 1);
   localparam int unsigned MIRROR_W = (CNT_W < XLEN) ? CNT_W : XLEN;

   state_t              r_state;
   state_t              w_next;
   logic [31:0]         r_ir;
   logic [WAIT_W-1:0]   r_wait;
   logic [CNT_W-1:0]    r_instret;
   logic                r_trap;
   logic [1:0]          r_cause;

   op_class_t           w_cls;
   logic [ALUCTR_W-1:0] w_alu_op;
   logic                w_alu_ill;
   logic                w_wait_hit;
   logic                w_retire;
   logic                w_set_trap;
   logic [1:0]          w_trap_cause;

   logic                w_mem_req, w_ir_write, w_pc_write, w_pc_src;
   logic [ALUCTR_W-1:0] w_aluctr;
   logic                w_immadd, w_branch, w_memread, w_memwrite;
   logic                w_memtoreg, w_regwrite, w_wb_link;
   logic                w_unused_ir;

   assign w_cls       = op_class(r_ir[6:0]);
   assign w_wait_hit  = (r_wait == WAIT_W'(TIMEOUT - 1));
   assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};

   alu_dec #(
      .ALUCTR_W (ALUCTR_W)
   ) u_alu_dec (
      .funct3  (r_ir[14:12]),
      .instr30 (r_ir[30]),
      .op_cls  (w_cls),
      .aluctr  (w_alu_op),
      .illegal (w_alu_ill)
   );

   // Next state and per-state control strobes.
   always_comb begin
      w_next       = r_state;
      w_mem_req    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 1'b0;
      w_aluctr     = '0;
      w_immadd     = 1'b0;
      w_branch     = 1'b0;
      w_memread    = 1'b0;
      w_memwrite   = 1'b0;
      w_memtoreg   = 1'b0;
      w_regwrite   = 1'b0;
      w_wb_link    = 1'b0;
      w_retire     = 1'b0;
      w_set_trap   = 1'b0;
      w_trap_cause = CAUSE_NONE;
      case (r_state)
         ST_FETCH: begin
            w_mem_req = 1'b1;
            if (mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_next     = ST_DECODE;
            end else if (w_wait_hit) begin
               w_set_trap   = 1'b1;
               w_trap_cause = CAUSE_TIMEOUT;
               w_next       = ST_TRAP;
            end
         end
         ST_DECODE: begin
            if (w_cls == CLS_BAD || w_alu_ill) begin
               w_set_trap   = 1'b1;
               w_trap_cause = CAUSE_ILLEGAL;
               w_next       = ST_TRAP;
            end else begin
               w_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            w_aluctr = w_alu_op;
            w_immadd = (w_cls == CLS_I) || (w_cls == CLS_LOAD) || (w_cls == CLS_STORE);
            case (w_cls)
               CLS_BRANCH: begin
                  w_branch   = 1'b1;
                  w_pc_write = branch_taken;
                  w_pc_src   = branch_taken;
                  w_retire   = 1'b1;
                  w_next     = ST_FETCH;
               end
               CLS_LOAD, CLS_STORE: w_next = ST_MEM;
               default:             w_next = ST_WB;
            endcase
         end
         ST_MEM: begin
            w_mem_req  = 1'b1;
            w_aluctr   = w_alu_op;
            w_immadd   = 1'b1;
            w_memread  = (w_cls == CLS_LOAD);
            w_memwrite = (w_cls == CLS_STORE);
            if (mem_ready) begin
               if (w_cls == CLS_LOAD) begin
                  w_next = ST_WB;
               end else begin
                  w_retire = 1'b1;
                  w_next   = ST_FETCH;
               end
            end else if (w_wait_hit) begin
               w_set_trap   = 1'b1;
               w_trap_cause = CAUSE_TIMEOUT;
               w_next       = ST_TRAP;
            end
         end
         ST_WB: begin
            w_aluctr   = w_alu_op;
            w_immadd   = (w_cls == CLS_I) || (w_cls == CLS_LOAD);
            w_regwrite = 1'b1;
            w_memtoreg = (w_cls == CLS_LOAD);
            w_wb_link  = (w_cls == CLS_JAL);
            w_pc_write = (w_cls == CLS_JAL);
            w_pc_src   = (w_cls == CLS_JAL);
            w_retire   = 1'b1;
            w_next     = ST_FETCH;
         end
         ST_TRAP: w_next = ST_TRAP;
         default: w_next = ST_FETCH;
      endcase
   end

   // State, instruction register, wait counter, trap and retire counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_FETCH;
         r_ir      <= '0;
         r_wait    <= '0;
         r_instret <= '0;
         r_trap    <= 1'b0;
         r_cause   <= CAUSE_NONE;
      end else begin
         r_state <= w_next;
         if (w_ir_write) r_ir <= instr;
         if (w_retire) r_instret <= r_instret + CNT_W'(1);
         if (w_set_trap && !r_trap) begin
            r_trap  <= 1'b1;
            r_cause <= w_trap_cause;
         end
         if (w_next != r_state)            r_wait <= '0;
         else if (w_mem_req && !mem_ready) r_wait <= r_wait + WAIT_W'(1);
         else                              r_wait <= '0;
      end
   end

   // Every output is forced low while reset is held.
   assign mem_req  = ~reset & w_mem_req;
   assign ir_write = ~reset & w_ir_write;
   assign pc_write = ~reset & w_pc_write;
   assign pc_src   = ~reset & w_pc_src;
   assign aluctr   = reset ? '0 : w_aluctr;
   assign immadd   = ~reset & w_immadd;
   assign branch   = ~reset & w_branch;
   assign memread  = ~reset & w_memread;
   assign memwrite = ~reset & w_memwrite;
   assign memtoreg = ~reset & w_memtoreg;
   assign regwrite = ~reset & w_regwrite;
   assign wb_link  = ~reset & w_wb_link;
   assign funct    = reset ? 3'd0 : r_ir[14:12];
   assign trap     = ~reset & r_trap;
   assign cause    = reset ? CAUSE_NONE : r_cause;
   assign instret  = reset ? '0 : CNT_W'(r_instret[MIRROR_W-1:0]);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle strobe checks, wait/timeout
// boundary, trap stickiness, reset mid-instruction and instret wrap.
module tb_mc_control_fsm;

   localparam int unsigned CNT_W    = 4;
   localparam int unsigned ALUCTR_W = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic [31:0]         instr;
   logic                mem_ready;
   logic                branch_taken;
   logic                mem_req, ir_write, pc_write, pc_src;
   logic [ALUCTR_W-1:0] aluctr;
   logic                immadd, branch, memread, memwrite;
   logic                memtoreg, regwrite, wb_link;
   logic [2:0]          funct;
   logic                trap;
   logic [1:0]          cause;
   logic [CNT_W-1:0]    instret;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mc_control_fsm #(
      .XLEN     (32),
      .CNT_W    (CNT_W),
      .TIMEOUT  (15),
      .ALUCTR_W (ALUCTR_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .instr        (instr),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .aluctr       (aluctr),
      .immadd       (immadd),
      .branch       (branch),
      .memread      (memread),
      .memwrite     (memwrite),
      .memtoreg     (memtoreg),
      .regwrite     (regwrite),
      .wb_link      (wb_link),
      .funct        (funct),
      .trap         (trap),
      .cause        (cause),
      .instret      (instret)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; instr = 32'h0; mem_ready = 1'b0; branch_taken = 1'b0;
      tick(); tick();
      chk("rst_mem_req",  32'(mem_req), 32'd0);
      chk("rst_regwrite", 32'(regwrite), 32'd0);
      chk("rst_instret",  32'(instret), 32'd0);
      chk("rst_trap",     32'(trap), 32'd0);
      chk("rst_cause",    32'(cause), 32'd0);
      reset = 1'b0;

      // ADD x3,x1,x2 with zero wait states
      instr = 32'h002081B3; mem_ready = 1'b1; #1;
      chk("add_f_mem_req",  32'(mem_req), 32'd1);
      chk("add_f_ir_write", 32'(ir_write), 32'd1);
      chk("add_f_pc_write", 32'(pc_write), 32'd1);
      chk("add_f_pc_src",   32'(pc_src), 32'd0);
      tick(); #1;
      chk("add_d_mem_req",  32'(mem_req), 32'd0);
      chk("add_d_regwrite", 32'(regwrite), 32'd0);
      tick(); #1;
      chk("add_e_aluctr",   32'(aluctr), 32'd0);
      chk("add_e_regwrite", 32'(regwrite), 32'd0);
      tick(); #1;
      chk("add_wb_regwrite", 32'(regwrite), 32'd1);
      chk("add_wb_aluctr",   32'(aluctr), 32'd0);
      chk("add_wb_instret",  32'(instret), 32'd0);
      tick(); #1;
      chk("add_instret",     32'(instret), 32'd1);
      chk("add_next_mem_req", 32'(mem_req), 32'd1);

      // LW with three wait cycles in MEM
      instr = 32'h0000A183; mem_ready = 1'b1; #1;
      chk("lw_f_ir_write", 32'(ir_write), 32'd1);
      tick(); mem_ready = 1'b0; #1;
      chk("lw_d_mem_req", 32'(mem_req), 32'd0);
      tick(); #1;
      chk("lw_e_immadd",  32'(immadd), 32'd1);
      chk("lw_e_aluctr",  32'(aluctr), 32'd0);
      chk("lw_e_memread", 32'(memread), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("lw_m_wait_memread", 32'(memread), 32'd1);
         chk("lw_m_wait_mem_req", 32'(mem_req), 32'd1);
      end
      tick(); mem_ready = 1'b1; #1;
      chk("lw_m_hs_memread", 32'(memread), 32'd1);
      chk("lw_m_funct",      32'(funct), 32'd2);
      tick(); #1;
      chk("lw_wb_memtoreg", 32'(memtoreg), 32'd1);
      chk("lw_wb_regwrite", 32'(regwrite), 32'd1);
      chk("lw_wb_memread",  32'(memread), 32'd0);
      chk("lw_wb_mem_req",  32'(mem_req), 32'd0);
      tick(); #1;
      chk("lw_instret",  32'(instret), 32'd2);
      chk("lw_fetch_req", 32'(mem_req), 32'd1);

      // BEQ taken
      instr = 32'h00000063; mem_ready = 1'b1; #1;
      tick(); tick(); branch_taken = 1'b1; #1;
      chk("beqt_branch",   32'(branch), 32'd1);
      chk("beqt_aluctr",   32'(aluctr), 32'd1);
      chk("beqt_pc_write", 32'(pc_write), 32'd1);
      chk("beqt_pc_src",   32'(pc_src), 32'd1);
      tick(); branch_taken = 1'b0; #1;
      chk("beqt_instret",  32'(instret), 32'd3);
      chk("beqt_fetch_req", 32'(mem_req), 32'd1);

      // BEQ not taken
      tick(); tick(); #1;
      chk("beqn_branch",   32'(branch), 32'd1);
      chk("beqn_pc_write", 32'(pc_write), 32'd0);
      chk("beqn_pc_src",   32'(pc_src), 32'd0);
      tick(); #1;
      chk("beqn_instret",  32'(instret), 32'd4);

      // ADDI fetched after 14 low-ready cycles: completes without trap
      instr = 32'h00500093; mem_ready = 1'b0; #1;
      repeat (14) tick();
      chk("near_to_mem_req", 32'(mem_req), 32'd1);
      chk("near_to_trap_pre", 32'(trap), 32'd0);
      mem_ready = 1'b1; #1;
      chk("near_to_ir_write", 32'(ir_write), 32'd1);
      tick(); tick(); #1;
      chk("addi_e_immadd", 32'(immadd), 32'd1);
      tick(); #1;
      chk("addi_wb_regwrite", 32'(regwrite), 32'd1);
      tick(); #1;
      chk("addi_instret", 32'(instret), 32'd5);
      chk("near_to_trap", 32'(trap), 32'd0);

      // SW interrupted by reset while in MEM
      instr = 32'h0020A023; mem_ready = 1'b1; #1;
      tick(); mem_ready = 1'b0; tick(); tick(); #1;
      chk("sw_m_memwrite", 32'(memwrite), 32'd1);
      reset = 1'b1; #1;
      chk("sw_rst_memwrite", 32'(memwrite), 32'd0);
      chk("sw_rst_mem_req",  32'(mem_req), 32'd0);
      tick(); reset = 1'b0; #1;
      chk("sw_after_instret",  32'(instret), 32'd0);
      chk("sw_after_mem_req",  32'(mem_req), 32'd1);
      chk("sw_after_memwrite", 32'(memwrite), 32'd0);

      // 16 branch retires wrap a 4-bit counter
      for (int i = 0; i < 16; i++) begin
         instr = 32'h00000063; mem_ready = 1'b1; branch_taken = 1'b0; #1;
         tick(); tick(); tick(); #1;
         if (i == 14) chk("wrap_15", 32'(instret), 32'd15);
         if (i == 15) chk("wrap_0",  32'(instret), 32'd0);
      end

      // Illegal opcode traps and holds
      instr = 32'h0000007F; mem_ready = 1'b1; #1;
      tick(); #1;
      chk("ill_d_trap", 32'(trap), 32'd0);
      tick(); #1;
      chk("ill_trap",    32'(trap), 32'd1);
      chk("ill_cause",   32'(cause), 32'd1);
      chk("ill_mem_req", 32'(mem_req), 32'd0);
      for (int i = 0; i < 20; i++) begin
         mem_ready = 1'(i & 1);
         tick(); #1;
         chk("ill_hold_trap",    32'(trap), 32'd1);
         chk("ill_hold_mem_req", 32'(mem_req), 32'd0);
         chk("ill_hold_instret", 32'(instret), 32'd0);
      end
      chk("ill_hold_cause", 32'(cause), 32'd1);

      // Illegal I-ALU funct3 011
      reset = 1'b1; tick(); reset = 1'b0; #1;
      chk("rst2_trap", 32'(trap), 32'd0);
      instr = 32'h00003013; mem_ready = 1'b1; #1;
      tick(); tick(); #1;
      chk("ifn_trap",  32'(trap), 32'd1);
      chk("ifn_cause", 32'(cause), 32'd1);

      // Fetch timeout: 15 low-ready cycles trap with cause 2
      reset = 1'b1; tick(); reset = 1'b0; mem_ready = 1'b0; #1;
      repeat (14) tick();
      chk("to_15th_trap",    32'(trap), 32'd0);
      chk("to_15th_mem_req", 32'(mem_req), 32'd1);
      tick(); #1;
      chk("to_trap",    32'(trap), 32'd1);
      chk("to_cause",   32'(cause), 32'd2);
      chk("to_mem_req", 32'(mem_req), 32'd0);
      mem_ready = 1'b1; tick(); #1;
      chk("to_cause_hold", 32'(cause), 32'd2);
      chk("to_ir_write",   32'(ir_write), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multi-cycle control unit that replaces the single-cycle decode-and-fire control path. It sequences fetch, decode, execute, memory and write-back over several cycles, and talks to instruction/data memory through a req/ready handshake with a bounded wait. It also traps on illegal opcodes and bus timeouts and counts retired instructions. It drives the existing pc_reg, RegFile, ALU and DataMem datapath through registered-instruction decode.

## Interface
Parameters:
- XLEN, 32: datapath width; only sets the width of `instret` mirroring, not decode.
- CNT_W, 32: width of retired-instruction counter.
- TIMEOUT, 15: maximum wait cycles on a memory handshake before trap (≥1).
- ALUCTR_W, 3: ALU operation code width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  32  fetched instruction from memory; captured on fetch handshake.
- mem_ready  in  1  memory completes transfer this cycle.
- branch_taken  in  1  ALU comparison result, valid in EXEC.
- mem_req  out  1  memory request (fetch or data).
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = PC+imm.
- aluctr  out  ALUCTR_W  ALU operation.
- immadd  out  1  ALU operand 2 = immediate.
- branch  out  1  ALU in compare mode.
- memread / memwrite  out  1 each  data access direction.
- memtoreg / regwrite  out  1 each  write-back source / enable.
- wb_link  out  1  write-back value is PC+4 (JAL).
- funct  out  3  registered funct3 to DataMem.
- trap  out  1  sticky fault.
- cause  out  2  0 none, 1 illegal instruction, 2 bus timeout.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: mem_req=1; on mem_req&&mem_ready: ir_write=1, pc_write=1, pc_src=0, go DECODE.
- DECODE: opcode from the registered instruction. Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL. Any other opcode, or an illegal ALU funct, goes to TRAP with cause=1.
- EXEC:
  - R / I-ALU / JAL go to WB.
  - LOAD / STORE go to MEM, with aluctr=ADD and immadd=1.
  - BRANCH: aluctr=SUB, branch=1. If branch_taken, pc_write=1 and pc_src=1. Retire, then go FETCH.
- MEM: mem_req=1 plus memread (LOAD) or memwrite (STORE). On handshake, LOAD goes to WB; STORE retires and goes to FETCH.
- WB: regwrite=1. memtoreg=1 for LOAD; wb_link=1 plus pc_write=1, pc_src=1 for JAL. Retire, go FETCH.
- ALU decode (funct3):
  - 000 gives ADD, or SUB when R-type and instr[30]=1.
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL.
  - 011 is illegal for R and I-ALU.
- Wait counter: increments each cycle mem_req=1 && mem_ready=0, and clears on handshake or state change. When it reaches TIMEOUT with ready still low, go to TRAP with cause=2.
- TRAP: all control outputs 0 and mem_req=0. Held until reset. cause holds its first value.
- Retire: instret += 1 (wraps modulo 2^CNT_W) in the final cycle of each instruction. Trapped instructions do not retire.

## Timing
- Reset values: state FETCH, instret 0, trap 0, cause 0, wait counter 0, instruction register 0. While reset is high, all outputs are 0, including mem_req.
- Control outputs are combinational from state plus the registered instruction. No combinational path from mem_ready to anything but mem_req-qualified strobes (ir_write, pc_write) and next state.
- Zero-wait-state latency:
  - BRANCH: 3 cycles.
  - R, I-ALU, STORE, JAL: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- mem_req stays high until the handshake cycle and drops the cycle after, unless the next state also requests.
- Reset asserted mid-instruction: the next edge returns to FETCH, with no retire and no register write that cycle (outputs gated).
- Timeout boundary: with TIMEOUT=15, ready arriving on the 15th wait cycle or earlier completes the transfer. 15 low cycles followed by the next edge traps.

## Structure
- Package `ctrl_pkg`: state enum, opcode constants, ALU op codes (ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, SRL 7), cause codes.
- Sub-module `alu_dec`: combinational funct3/instr[30]/opcode class → aluctr and illegal flag.
- Top holds the FSM, instruction register, wait counter and instret.

## Test plan
- ADD x3,x1,x2 (0x002081B3), mem_ready tied 1 → regwrite in cycle 4, aluctr=0, instret 0→1.
- LW (0x0000A183) with ready delayed 3 cycles in MEM → memread held 4 cycles, memtoreg+regwrite in WB, total 8 cycles.
- BEQ with branch_taken=1 → pc_write=1, pc_src=1 in EXEC, 3 cycles; with branch_taken=0 → pc_src=0, no pc_write in EXEC.
- Opcode 0x0000007F → TRAP, cause=1, trap stays 1 and mem_req=0 for 20 cycles, instret unchanged.
- mem_ready held 0 in FETCH → trap at wait count 15 with cause=2. Repeat with ready on wait cycle 15 → no trap.
- Reset asserted during MEM of SW → no memwrite after reset, state FETCH, instret=0. CNT_W=4 with 16 retires → instret wraps to 0.
